display_mode_scheduler: RTL and testbench

Sequences display-mode changes for the single/2x2/3x3 display mux. It synchronizes and debounces the two raw mode buttons and turns presses into a target mode. It defers each change to a frame boundary, then runs a clear handshake with the display datapath before committing the new mux select. It sits between the board buttons and the display mux/datapath, replacing direct combinational decoding of the toggle inputs.

---
 rtl/display_mode_scheduler.sv | 156 +++++++++++++++
 tb/tb_display_mode_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_scheduler.sv
// Display-mode change sequencer: debounces the two mode buttons, defers each change
// to a frame boundary and runs a clear handshake before committing the mux select.
module display_mode_scheduler #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       btn_2by2,
  input  logic       btn_3by3,
  input  logic       frame_done,
  input  logic       clr_ack,
  output logic       clr_req,
  output logic [1:0] mode_sel,
  output logic       mode_chg,
  output logic       busy,
  output logic       err_timeout
);

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_2BY2   = 2'b01;
  localparam logic [1:0] MODE_3BY3   = 2'b10;
  localparam logic [7:0] DEB_LAST    = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PEND, CLEAR, APPLY} state_t;

  // Bit 0 is the 2x2 button, bit 1 the 3x3 button.
  logic [1:0] raw_btn;
  logic [1:0] sync1_q, sync2_q, stable_q, press_q;
  logic [7:0] deb_cnt_q [2];

  assign raw_btn = {btn_3by3, btn_2by2};

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_btn;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] != stable_q[i]) begin
          if (deb_cnt_q[i] == DEB_LAST) begin
            stable_q[i]  <= sync2_q[i];
            press_q[i]   <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 8'd1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  state_t     state_q;
  logic [1:0] tgt_q, slot_tgt_q, mode_sel_q;
  logic [7:0] to_cnt_q;
  logic       slot_q, clr_req_q, mode_chg_q, busy_q, err_q;

  logic       press_any;
  logic [1:0] ref_mode, press_tgt, pend_tgt;

  // Each button toggles between its own mode and single; 3x3 wins a tie.
  function automatic logic [1:0] toggle_target(input logic [1:0] base, input logic is_3by3);
    if (is_3by3) return (base == MODE_3BY3) ? MODE_SINGLE : MODE_3BY3;
    return (base == MODE_2BY2) ? MODE_SINGLE : MODE_2BY2;
  endfunction

  assign press_any = |press_q;
  assign ref_mode  = (state_q == IDLE) ? mode_sel_q : tgt_q;
  assign press_tgt = toggle_target(ref_mode, press_q[1]);
  assign pend_tgt  = press_any ? press_tgt : tgt_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      tgt_q      <= MODE_SINGLE;
      slot_q     <= 1'b0;
      slot_tgt_q <= MODE_SINGLE;
      mode_sel_q <= MODE_SINGLE;
      to_cnt_q   <= '0;
      clr_req_q  <= 1'b0;
      mode_chg_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mode_chg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_any && press_tgt != mode_sel_q) begin
            tgt_q   <= press_tgt;
            state_q <= PEND;
            busy_q  <= 1'b1;
          end
        end
        PEND: begin
          tgt_q <= pend_tgt;
          if (pend_tgt == mode_sel_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (frame_done) begin
            state_q   <= CLEAR;
            clr_req_q <= 1'b1;
            to_cnt_q  <= '0;
          end
        end
        CLEAR: begin
          if (press_any) begin
            slot_q     <= 1'b1;
            slot_tgt_q <= press_tgt;
          end
          if (clr_ack || to_cnt_q == TO_LAST) begin
            if (!clr_ack) err_q <= 1'b1;
            clr_req_q  <= 1'b0;
            mode_sel_q <= tgt_q;
            mode_chg_q <= 1'b1;
            state_q    <= APPLY;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        APPLY: begin
          // A press landing in APPLY replaces the slot; tgt_q already equals mode_sel.
          if (slot_q || press_any) begin
            tgt_q   <= press_any ? press_tgt : slot_tgt_q;
            slot_q  <= 1'b0;
            state_q <= PEND;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_req     = clr_req_q;
  assign mode_sel    = mode_sel_q;
  assign mode_chg    = mode_chg_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Directed bench for display_mode_scheduler with DEB_CYCLES=4 and TIMEOUT=16.
module tb_display_mode_scheduler;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       btn_2by2 = 1'b0, btn_3by3 = 1'b0, frame_done = 1'b0, clr_ack = 1'b0;
  logic       clr_req, mode_chg, busy, err_timeout;
  logic [1:0] mode_sel;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;
  int clr_cnt = 0;

  display_mode_scheduler #(.DEB_CYCLES(4), .TIMEOUT(16)) dut (
    .clk(clk), .rstb(rstb), .btn_2by2(btn_2by2), .btn_3by3(btn_3by3),
    .frame_done(frame_done), .clr_ack(clr_ack), .clr_req(clr_req),
    .mode_sel(mode_sel), .mode_chg(mode_chg), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample 1 ns after the edge; tallies pulse activity.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mode_chg) chg_cnt++;
    if (clr_req) clr_cnt++;
  endtask

  task automatic gap();
    repeat (6) tick();
  endtask

  // Holds the buttons until the debounced press pulse, then lets the FSM consume it.
  task automatic do_press(input logic b2, input logic b3);
    btn_2by2 = b2;
    btn_3by3 = b3;
    repeat (6) tick();
    btn_2by2 = 1'b0;
    btn_3by3 = 1'b0;
    tick();
  endtask

  task automatic frame_pulse();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic ack_pulse();
    clr_ack = 1'b1;
    tick();
    clr_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rstb = 1'b0;
    repeat (2) tick();
    rstb = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_2by2 = i[0];
      btn_3by3 = ~i[0];
      tick();
    end
    checks++;
    if ({clr_req, mode_sel, mode_chg, busy, err_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b expected 000000",
               {clr_req, mode_sel, mode_chg, busy, err_timeout});
    end
    btn_2by2 = 1'b0;
    btn_3by3 = 1'b0;
    chg_cnt  = 0;
    clr_cnt  = 0;
    rstb     = 1'b1;
    repeat (20) tick();
    checks++;
    if ({clr_req, mode_sel, mode_chg, busy, err_timeout} !== 6'b0 || chg_cnt != 0 || clr_cnt != 0) begin
      errors++;
      $display("FAIL reset_quiet: outputs=%b chg=%0d clr=%0d expected 000000/0/0",
               {clr_req, mode_sel, mode_chg, busy, err_timeout}, chg_cnt, clr_cnt);
    end
  endtask

  task automatic test_debounce();
    btn_2by2 = 1'b1;
    repeat (3) tick();
    btn_2by2 = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL deb_glitch: busy=%b expected 0", busy);
    end
    btn_2by2 = 1'b1;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL deb_early: busy=%b expected 0", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL deb_pend: busy=%b expected 1", busy);
    end
    repeat (3) tick();
    btn_2by2 = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy !== 1'b1 || clr_req !== 1'b0) begin
      errors++;
      $display("FAIL deb_wait: busy=%b clr_req=%b expected 1/0", busy, clr_req);
    end
    clr_cnt = 0;
    do_press(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0 || clr_cnt != 0 || mode_sel !== 2'b00) begin
      errors++;
      $display("FAIL deb_cancel: busy=%b clr=%0d mode_sel=%b expected 0/0/00", busy, clr_cnt, mode_sel);
    end
  endtask

  task automatic test_full_sequence();
    gap();
    chg_cnt = 0;
    do_press(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || mode_sel !== 2'b00) begin
      errors++;
      $display("FAIL full_pend: busy=%b mode_sel=%b expected 1/00", busy, mode_sel);
    end
    repeat (4) tick();
    frame_pulse();
    checks++;
    if (clr_req !== 1'b1) begin
      errors++;
      $display("FAIL full_clr_req: clr_req=%b expected 1", clr_req);
    end
    tick();
    tick();
    ack_pulse();
    checks++;
    if (mode_sel !== 2'b01 || mode_chg !== 1'b1 || clr_req !== 1'b0) begin
      errors++;
      $display("FAIL full_apply: mode_sel=%b chg=%b clr_req=%b expected 01/1/0", mode_sel, mode_chg, clr_req);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mode_chg !== 1'b0 || chg_cnt != 1) begin
      errors++;
      $display("FAIL full_idle: busy=%b chg=%b pulses=%0d expected 0/0/1", busy, mode_chg, chg_cnt);
    end
    gap();
    do_press(1'b1, 1'b0);
    frame_pulse();
    ack_pulse();
    tick();
    checks++;
    if (mode_sel !== 2'b00 || chg_cnt != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_back: mode_sel=%b pulses=%0d busy=%b expected 00/2/0", mode_sel, chg_cnt, busy);
    end
  endtask

  task automatic test_retarget();
    gap();
    do_press(1'b0, 1'b1);
    gap();
    do_press(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || clr_req !== 1'b0) begin
      errors++;
      $display("FAIL retarget_pend: busy=%b clr_req=%b expected 1/0", busy, clr_req);
    end
    frame_pulse();
    ack_pulse();
    checks++;
    if (mode_sel !== 2'b01 || mode_chg !== 1'b1) begin
      errors++;
      $display("FAIL retarget_mode: mode_sel=%b chg=%b expected 01/1", mode_sel, mode_chg);
    end
    tick();
    gap();
    do_press(1'b1, 1'b0);
    frame_pulse();
    ack_pulse();
    tick();
    gap();
    clr_cnt = 0;
    do_press(1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cancel_pend: busy=%b expected 1", busy);
    end
    gap();
    do_press(1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || clr_cnt != 0 || mode_sel !== 2'b00) begin
      errors++;
      $display("FAIL cancel_idle: busy=%b clr=%0d mode_sel=%b expected 0/0/00", busy, clr_cnt, mode_sel);
    end
  endtask

  task automatic test_timeout();
    gap();
    do_press(1'b1, 1'b0);
    clr_cnt = 0;
    frame_pulse();
    repeat (15) tick();
    checks++;
    if (clr_req !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_last_cycle: clr_req=%b err=%b expected 1/0", clr_req, err_timeout);
    end
    tick();
    checks++;
    if (clr_req !== 1'b0 || err_timeout !== 1'b1 || mode_sel !== 2'b01 || mode_chg !== 1'b1 || clr_cnt != 16) begin
      errors++;
      $display("FAIL to_expire: clr_req=%b err=%b mode_sel=%b chg=%b clr_cycles=%0d expected 0/1/01/1/16",
               clr_req, err_timeout, mode_sel, mode_chg, clr_cnt);
    end
    tick();
    gap();
    do_press(1'b1, 1'b0);
    frame_pulse();
    ack_pulse();
    checks++;
    if (err_timeout !== 1'b1 || mode_sel !== 2'b00) begin
      errors++;
      $display("FAIL to_sticky: err=%b mode_sel=%b expected 1/00", err_timeout, mode_sel);
    end
    tick();
    apply_reset();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_reset_clear: err=%b expected 0", err_timeout);
    end
    do_press(1'b1, 1'b0);
    frame_pulse();
    repeat (15) tick();
    clr_ack = 1'b1;
    tick();
    clr_ack = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || mode_sel !== 2'b01 || mode_chg !== 1'b1) begin
      errors++;
      $display("FAIL to_ack_wins: err=%b mode_sel=%b chg=%b expected 0/01/1", err_timeout, mode_sel, mode_chg);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    do_press(1'b1, 1'b1);
    frame_pulse();
    ack_pulse();
    checks++;
    if (mode_sel !== 2'b10) begin
      errors++;
      $display("FAIL simul_3by3: mode_sel=%b expected 10", mode_sel);
    end
    tick();
  endtask

  task automatic test_pending();
    apply_reset();
    chg_cnt = 0;
    do_press(1'b0, 1'b1);
    frame_pulse();
    do_press(1'b1, 1'b0);
    checks++;
    if (clr_req !== 1'b1) begin
      errors++;
      $display("FAIL pend_in_clear: clr_req=%b expected 1", clr_req);
    end
    ack_pulse();
    checks++;
    if (mode_sel !== 2'b10 || mode_chg !== 1'b1) begin
      errors++;
      $display("FAIL pend_apply1: mode_sel=%b chg=%b expected 10/1", mode_sel, mode_chg);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || clr_req !== 1'b0 || mode_chg !== 1'b0) begin
      errors++;
      $display("FAIL pend_repend: busy=%b clr_req=%b chg=%b expected 1/0/0", busy, clr_req, mode_chg);
    end
    frame_pulse();
    ack_pulse();
    tick();
    checks++;
    if (mode_sel !== 2'b01 || busy !== 1'b0 || chg_cnt != 2) begin
      errors++;
      $display("FAIL pend_apply2: mode_sel=%b busy=%b pulses=%0d expected 01/0/2", mode_sel, busy, chg_cnt);
    end
  endtask

  task automatic test_reset_mid_clear();
    gap();
    do_press(1'b0, 1'b1);
    frame_pulse();
    checks++;
    if (clr_req !== 1'b1 || mode_sel !== 2'b01) begin
      errors++;
      $display("FAIL rst_setup: clr_req=%b mode_sel=%b expected 1/01", clr_req, mode_sel);
    end
    #2;
    rstb = 1'b0;
    #1;
    checks++;
    if (mode_sel !== 2'b00 || clr_req !== 1'b0 || mode_chg !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: mode_sel=%b clr_req=%b chg=%b busy=%b expected 00/0/0/0",
               mode_sel, clr_req, mode_chg, busy);
    end
    tick();
    rstb = 1'b1;
    chg_cnt = 0;
    repeat (3) tick();
    checks++;
    if (chg_cnt != 0 || busy !== 1'b0 || mode_sel !== 2'b00) begin
      errors++;
      $display("FAIL rst_after: pulses=%0d busy=%b mode_sel=%b expected 0/0/00", chg_cnt, busy, mode_sel);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_sequence();
    test_retarget();
    test_timeout();
    test_simultaneous();
    test_pending();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
